// File: rtl/operators_pkg.sv
// Shared widths and opcode encodings for the registered operator unit.
package operators_pkg;

  localparam int WIDTH  = 8;
  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [CODE_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [CODE_W-1:0] OP_MUL  = 4'b0010;
  localparam logic [CODE_W-1:0] OP_LAND = 4'b0011;
  localparam logic [CODE_W-1:0] OP_AND  = 4'b0100;
  localparam logic [CODE_W-1:0] OP_LOR  = 4'b0101;
  localparam logic [CODE_W-1:0] OP_XOR  = 4'b0110;
  localparam logic [CODE_W-1:0] OP_NOT  = 4'b0111;
  localparam logic [CODE_W-1:0] OP_OR   = 4'b1000;
  localparam logic [CODE_W-1:0] OP_SHL  = 4'b1001;
  localparam logic [CODE_W-1:0] OP_SHR  = 4'b1010;
  localparam logic [CODE_W-1:0] OP_EQ   = 4'b1011;
  localparam logic [CODE_W-1:0] OP_LT   = 4'b1100;
  localparam logic [CODE_W-1:0] OP_GT   = 4'b1101;
  localparam logic [CODE_W-1:0] OP_LNOT = 4'b1110;
  localparam logic [CODE_W-1:0] OP_RSVD = 4'b1111;

endpackage

// File: rtl/operators_core.sv
// Combinational operator select: maps code/a/b to the next result value.
module operators_core
  import operators_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [CODE_W-1:0] code,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic [W-1:0]      next_result
);

  localparam logic [W-1:0] SHIFT_LIMIT = W[W-1:0];

  logic [2*W-1:0] product_s;
  logic           shift_oob_s;
  logic [W-1:0]   next_s;

  // Full-width product so the low half is exact before truncation.
  always_comb begin
    product_s   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    shift_oob_s = (b >= SHIFT_LIMIT);
  end

  // Boolean-valued ops return a zero-extended single bit.
  always_comb begin
    next_s = {W{1'b0}};
    case (code)
      OP_ADD:  next_s = a + b;
      OP_SUB:  next_s = a - b;
      OP_MUL:  next_s = product_s[W-1:0];
      OP_LAND: next_s = {{(W-1){1'b0}}, ((a != {W{1'b0}}) && (b != {W{1'b0}}))};
      OP_AND:  next_s = a & b;
      OP_LOR:  next_s = {{(W-1){1'b0}}, ((a != {W{1'b0}}) || (b != {W{1'b0}}))};
      OP_XOR:  next_s = a ^ b;
      OP_NOT:  next_s = ~a;
      OP_OR:   next_s = a | b;
      OP_SHL: begin
        if (shift_oob_s) next_s = {W{1'b0}};
        else             next_s = a << b;
      end
      OP_SHR: begin
        if (shift_oob_s) next_s = {W{1'b0}};
        else             next_s = a >> b;
      end
      OP_EQ:   next_s = {{(W-1){1'b0}}, (a == b)};
      OP_LT:   next_s = {{(W-1){1'b0}}, (a < b)};
      OP_GT:   next_s = {{(W-1){1'b0}}, (a > b)};
      OP_LNOT: next_s = {{(W-1){1'b0}}, (a == {W{1'b0}})};
      OP_RSVD: next_s = {W{1'b0}};
      default: next_s = {W{1'b0}};
    endcase
  end

  assign next_result = next_s;

endmodule

// File: rtl/operators_alu.sv
// Registered 8-bit operator unit: combinational core plus one result register.
module operators_alu
  import operators_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic [W-1:0]      result
);

  logic [W-1:0] next_result_s;
  logic [W-1:0] result_r;

  operators_core #(.W(W)) u_core (
    .code        (code),
    .a           (a),
    .b           (b),
    .next_result (next_result_s)
  );

  // Result register; reset clears it immediately, dropping any pending value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) result_r <= {W{1'b0}};
    else     result_r <= next_result_s;
  end

  assign result = result_r;

endmodule

// File: tb/tb_operators_alu.sv
// Self-checking bench for operators_alu: directed table, random vs. model, reset sequences.
module tb_operators_alu;

  logic       clk;
  logic       rst;
  logic [3:0] code;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;

  int total;
  int bad;

  typedef struct {
    logic [3:0] code;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[19];

  operators_alu dut (
    .clk    (clk),
    .rst    (rst),
    .code   (code),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference computed with plain integer arithmetic from the opcode table.
  function automatic logic [7:0] model(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    int ia, ib, r;
    ia = int'(x);
    ib = int'(y);
    case (c)
      4'd0:  r = (ia + ib) % 256;
      4'd1:  r = (ia - ib + 256) % 256;
      4'd2:  r = (ia * ib) % 256;
      4'd3:  r = (ia != 0 && ib != 0) ? 1 : 0;
      4'd4:  r = ia & ib;
      4'd5:  r = (ia != 0 || ib != 0) ? 1 : 0;
      4'd6:  r = ia ^ ib;
      4'd7:  r = 255 - ia;
      4'd8:  r = ia | ib;
      4'd9:  r = (ib >= 8) ? 0 : (ia * (2 ** ib)) % 256;
      4'd10: r = (ib >= 8) ? 0 : ia / (2 ** ib);
      4'd11: r = (ia == ib) ? 1 : 0;
      4'd12: r = (ia < ib) ? 1 : 0;
      4'd13: r = (ia > ib) ? 1 : 0;
      4'd14: r = (ia == 0) ? 1 : 0;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%02h expected=0x%02h", name, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    code = c;
    a    = x;
    b    = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{4'd0,  8'd10,   8'd6,    8'd16};
    vecs[1]  = '{4'd0,  8'd250,  8'd10,   8'd4};
    vecs[2]  = '{4'd4,  8'h2B,   8'hCC,   8'h08};
    vecs[3]  = '{4'd6,  8'h2B,   8'hCC,   8'hE7};
    vecs[4]  = '{4'd5,  8'h2B,   8'hCC,   8'd1};
    vecs[5]  = '{4'd5,  8'd0,    8'd0,    8'd0};
    vecs[6]  = '{4'd3,  8'h2B,   8'd0,    8'd0};
    vecs[7]  = '{4'd7,  8'h2B,   8'h5A,   8'hD4};
    vecs[8]  = '{4'd14, 8'd0,    8'h77,   8'd1};
    vecs[9]  = '{4'd9,  8'h81,   8'd1,    8'h02};
    vecs[10] = '{4'd9,  8'h81,   8'd8,    8'h00};
    vecs[11] = '{4'd12, 8'd3,    8'd5,    8'd1};
    vecs[12] = '{4'd15, 8'hFF,   8'hFF,   8'h00};
    vecs[13] = '{4'd1,  8'd3,    8'd5,    8'hFE};
    vecs[14] = '{4'd2,  8'h10,   8'h17,   8'h70};
    vecs[15] = '{4'd10, 8'h80,   8'd7,    8'h01};
    vecs[16] = '{4'd11, 8'd5,    8'd5,    8'd1};
    vecs[17] = '{4'd13, 8'd5,    8'd3,    8'd1};
    vecs[18] = '{4'd3,  8'h01,   8'h80,   8'd1};

    // Reset asserted with nonzero inputs, before any clock edge
    rst  = 1'b0;
    code = 4'd0;
    a    = 8'd9;
    b    = 8'd7;
    #1 rst = 1'b1;
    #2;
    check("reset_before_clock", result, 8'h00);
    @(posedge clk); #1;
    check("reset_held_edge1", result, 8'h00);
    @(posedge clk); #1;
    check("reset_held_edge2", result, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_no_edge", result, 8'h00);

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].code, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_op%0d", i, vecs[i].code), result, vecs[i].exp);
    end

    // Inputs changing between edges must not disturb the registered result
    apply(4'd0, 8'd100, 8'd27);
    code = 4'd2;
    a    = 8'd77;
    #2;
    check("hold_between_edges", result, 8'd127);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] rc;
      logic [7:0] ra, rb;
      rc = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = (rc == 4'd9 || rc == 4'd10) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'd0;
      if ($urandom_range(0, 7) == 0) rb = ra;
      apply(rc, ra, rb);
      check($sformatf("rand%0d_op%0d_a%0d_b%0d", i, rc, ra, rb), result, model(rc, ra, rb));
    end

    // Mid-stream reset: clears at once and nothing pending survives
    apply(4'd8, 8'hF0, 8'h0F);
    check("pre_midreset", result, 8'hFF);
    code = 4'd0;
    a    = 8'd1;
    b    = 8'd2;
    #1 rst = 1'b1;
    #1;
    check("midreset_async", result, 8'h00);
    @(posedge clk); #1;
    check("midreset_held", result, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_release_no_edge", result, 8'h00);
    @(posedge clk); #1;
    check("midreset_first_edge", result, 8'd3);
    apply(4'd7, 8'h00, 8'hAA);
    check("post_reset_not", result, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
